// File: rtl/round_robin_requester_if.sv
// Producer/arbiter-facing signal bundle of the round robin requester.
// slave: the requester itself; master: the producer plus arbiter side that drives it.
interface round_robin_requester_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          wr_en;
  logic [4*DATA_W-1:0] wr_data;
  logic [3:0]          grant_in;
  logic [3:0]          request_queue;
  logic [3:0]          full;
  logic [3:0]          wr_drop;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_id;
  logic                grant_err;

  modport slave (
    input  wr_en, wr_data, grant_in,
    output request_queue, full, wr_drop, out_valid, out_data, out_id, grant_err
  );

  modport master (
    output wr_en, wr_data, grant_in,
    input  request_queue, full, wr_drop, out_valid, out_data, out_id, grant_err
  );
endinterface

// File: rtl/round_robin_requester.sv
// Client side of a 4-line round robin arbiter: four per-line FIFOs, request per non-empty
// FIFO, and one pop per new one-hot grant, presented one clock after the grant is sampled.
module round_robin_requester #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  round_robin_requester_if.slave  bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [4][DEPTH];
  logic [PTR_W-1:0]  rd_ptr [4];
  logic [PTR_W-1:0]  wr_ptr [4];
  logic [PTR_W:0]    count  [4];

  logic [3:0]        grant_q;
  logic              grant_onehot;
  logic              grant_multi;
  logic              new_grant;
  logic [1:0]        grant_idx;
  logic [3:0]        pop;
  logic [3:0]        push;

  logic [3:0]        wr_drop_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [1:0]        out_id_q;
  logic              grant_err_q;

  // A grant held across an arbiter time slice is only "new" on its first sampled cycle.
  always_comb begin
    grant_onehot = (bus.grant_in != 4'd0) && ((bus.grant_in & (bus.grant_in - 4'd1)) == 4'd0);
    grant_multi  = (bus.grant_in != 4'd0) && !grant_onehot;
    new_grant    = grant_onehot && (bus.grant_in != grant_q);
    grant_idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.grant_in[i]) grant_idx = 2'(i);
    end
  end

  // A full FIFO still accepts a push when the same cycle pops it.
  always_comb begin
    pop  = 4'd0;
    push = 4'd0;
    for (int i = 0; i < 4; i++) begin
      pop[i]  = new_grant && bus.grant_in[i] && (count[i] != '0);
      push[i] = bus.wr_en[i] && ((count[i] != FULL_CNT) || pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.wr_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      grant_q     <= 4'd0;
      wr_drop_q   <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 2'd0;
      grant_err_q <= 1'b0;
    end else begin
      grant_q     <= bus.grant_in;
      out_valid_q <= |pop;
      if (grant_multi) grant_err_q <= 1'b1;
      if (|pop) begin
        out_data_q <= mem[grant_idx][rd_ptr[grant_idx]];
        out_id_q   <= grant_idx;
      end
      for (int i = 0; i < 4; i++) begin
        wr_drop_q[i] <= bus.wr_en[i] && !push[i];
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.request_queue[i] = (count[i] != '0);
      bus.full[i]          = (count[i] == FULL_CNT);
    end
  end

  assign bus.wr_drop   = wr_drop_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.grant_err = grant_err_q;

endmodule
